// File: rtl/waves_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : waves_trigger_ctrl
// Description : Trigger-driven capture window controller. Once armed, it
//               waits for any enabled trigger channel, counts a programmable
//               delay, then holds dump_en high for a programmable window.
//               Supports one-shot, repeat (with an optional window limit)
//               and continuous modes.
// Ports       : clk, rst            - clock / synchronous active-high reset
//               arm, force_off      - control pulses
//               cfg_*               - configuration, latched on accepted arm
//               trig_in             - trigger levels, one per channel
//               dump_en             - capture window open (registered)
//               dump_on_pulse       - first cycle of dump_en
//               dump_off_pulse      - first cycle after dump_en falls
//               state               - 0 IDLE,1 ARMED,2 DELAY,3 CAPTURE,4 DONE
//               window_count        - completed windows since last arm
//               trig_hit_id         - lowest enabled channel of last trigger
// Revision    : 1.0 - initial release
// ============================================================================
module waves_trigger_ctrl #(
    parameter int NUM_TRIG = 4,
    parameter int CNT_W    = 32,
    parameter int ID_W     = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                force_off,
    input  logic [1:0]          cfg_mode,
    input  logic [NUM_TRIG-1:0] cfg_trig_mask,
    input  logic [CNT_W-1:0]    cfg_delay,
    input  logic [CNT_W-1:0]    cfg_length,
    input  logic [7:0]          cfg_max_windows,
    input  logic [NUM_TRIG-1:0] trig_in,
    output logic                dump_en,
    output logic                dump_on_pulse,
    output logic                dump_off_pulse,
    output logic [2:0]          state,
    output logic [7:0]          window_count,
    output logic [ID_W-1:0]     trig_hit_id
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [1:0]       c_MODE_OFF  = 2'd0;
    localparam logic [1:0]       c_MODE_ONE  = 2'd1;
    localparam logic [1:0]       c_MODE_CONT = 2'd3;
    localparam logic [CNT_W-1:0] c_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_mode;
    logic [NUM_TRIG-1:0] r_mask;
    logic [CNT_W-1:0]    r_delay;
    logic [CNT_W-1:0]    r_length;
    logic [7:0]          r_max;
    logic                r_dump_en;
    logic                r_on_pulse;
    logic                r_off_pulse;
    logic [7:0]          r_win_cnt;
    logic [ID_W-1:0]     r_hit_id;

    logic [NUM_TRIG-1:0] w_hit_vec;
    logic [ID_W-1:0]     w_hit_id;
    logic [CNT_W-1:0]    w_len_eff;
    logic [7:0]          w_win_inc;

    // Lowest-index enabled channel wins: scan downward so the last hit
    // assigned is the smallest index.
    always_comb begin
        w_hit_vec = trig_in & r_mask;
        w_hit_id  = '0;
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit_id = i[ID_W-1:0];
            end
        end
    end

    // A zero-length window still opens for one cycle.
    assign w_len_eff = (r_length == '0) ? c_ONE : r_length;
    assign w_win_inc = (r_win_cnt == 8'hFF) ? 8'hFF : (r_win_cnt + 8'd1);

    // The shared counter holds the cycles remaining in the current DELAY or
    // CAPTURE phase; a phase ends in the cycle where it reads one, so the
    // full CNT_W range is usable without wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mode      <= '0;
            r_mask      <= '0;
            r_delay     <= '0;
            r_length    <= '0;
            r_max       <= '0;
            r_dump_en   <= 1'b0;
            r_on_pulse  <= 1'b0;
            r_off_pulse <= 1'b0;
            r_win_cnt   <= '0;
            r_hit_id    <= '0;
        end else begin
            r_on_pulse  <= 1'b0;
            r_off_pulse <= 1'b0;
            if (force_off) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_dump_en   <= 1'b0;
                r_off_pulse <= r_dump_en;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (arm && (cfg_mode != c_MODE_OFF)) begin
                            r_mode    <= cfg_mode;
                            r_mask    <= cfg_trig_mask;
                            r_delay   <= cfg_delay;
                            r_length  <= cfg_length;
                            r_max     <= cfg_max_windows;
                            r_win_cnt <= '0;
                            if (cfg_mode == c_MODE_CONT) begin
                                r_state    <= S_CAPTURE;
                                r_dump_en  <= 1'b1;
                                r_on_pulse <= 1'b1;
                            end else begin
                                r_state <= S_ARMED;
                            end
                        end
                    end
                    S_ARMED: begin
                        if (|w_hit_vec) begin
                            r_hit_id <= w_hit_id;
                            if (r_delay != '0) begin
                                r_state <= S_DELAY;
                                r_cnt   <= r_delay;
                            end else begin
                                r_state    <= S_CAPTURE;
                                r_cnt      <= w_len_eff;
                                r_dump_en  <= 1'b1;
                                r_on_pulse <= 1'b1;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (r_cnt == c_ONE) begin
                            r_state    <= S_CAPTURE;
                            r_cnt      <= w_len_eff;
                            r_dump_en  <= 1'b1;
                            r_on_pulse <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - c_ONE;
                        end
                    end
                    S_CAPTURE: begin
                        // Continuous mode never closes its window on its own.
                        if (r_mode != c_MODE_CONT) begin
                            if (r_cnt == c_ONE) begin
                                r_cnt       <= '0;
                                r_dump_en   <= 1'b0;
                                r_off_pulse <= 1'b1;
                                r_win_cnt   <= w_win_inc;
                                if ((r_mode == c_MODE_ONE) ||
                                    ((r_max != 8'd0) && (w_win_inc == r_max))) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_state <= S_ARMED;
                                end
                            end else begin
                                r_cnt <= r_cnt - c_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_dump_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dump_en        = r_dump_en;
    assign dump_on_pulse  = r_on_pulse;
    assign dump_off_pulse = r_off_pulse;
    assign state          = r_state;
    assign window_count   = r_win_cnt;
    assign trig_hit_id    = r_hit_id;

endmodule
`default_nettype wire

// File: tb/tb_waves_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_waves_trigger_ctrl
// Description : Self-checking bench for waves_trigger_ctrl. A reference model
//               describes each capture window by its absolute start and end
//               cycle numbers; every cycle all DUT outputs are compared with
//               the model. Directed scenarios are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_waves_trigger_ctrl;

    localparam int NUM_TRIG = 4;
    localparam int CNT_W    = 32;
    localparam int ID_W     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                arm;
    logic                force_off;
    logic [1:0]          cfg_mode;
    logic [NUM_TRIG-1:0] cfg_trig_mask;
    logic [CNT_W-1:0]    cfg_delay;
    logic [CNT_W-1:0]    cfg_length;
    logic [7:0]          cfg_max_windows;
    logic [NUM_TRIG-1:0] trig_in;
    logic                dump_en;
    logic                dump_on_pulse;
    logic                dump_off_pulse;
    logic [2:0]          state;
    logic [7:0]          window_count;
    logic [ID_W-1:0]     trig_hit_id;

    waves_trigger_ctrl #(.NUM_TRIG(NUM_TRIG), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .force_off      (force_off),
        .cfg_mode       (cfg_mode),
        .cfg_trig_mask  (cfg_trig_mask),
        .cfg_delay      (cfg_delay),
        .cfg_length     (cfg_length),
        .cfg_max_windows(cfg_max_windows),
        .trig_in        (trig_in),
        .dump_en        (dump_en),
        .dump_on_pulse  (dump_on_pulse),
        .dump_off_pulse (dump_off_pulse),
        .state          (state),
        .window_count   (window_count),
        .trig_hit_id    (trig_hit_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_dump_hi = 0;
    int n_off     = 0;
    longint cyc  = 0;

    // Reference model: phase 0 idle, 1 armed, 2 triggered window pending or
    // open, 3 continuous, 4 done. A triggered window spans [m_start, m_end].
    int     m_phase = 0;
    longint m_start = 0;
    longint m_end   = 0;
    int     m_mode = 0, m_mask = 0, m_max = 0, m_count = 0, m_id = 0;
    longint m_delay = 0, m_len = 0;
    bit     m_dump_prev = 1'b0;
    bit     m_rst_edge  = 1'b0;

    function automatic int lowest_bit(input int v);
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_update();
        longint t = cyc;
        m_rst_edge = rst;
        if (rst) begin
            m_phase = 0; m_mode = 0; m_mask = 0; m_max = 0; m_count = 0;
            m_id = 0; m_delay = 0; m_len = 0;
        end else if (force_off) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0, 4: if (arm && cfg_mode != 0) begin
                    m_mode  = int'(cfg_mode);
                    m_mask  = int'(cfg_trig_mask);
                    m_delay = longint'(cfg_delay);
                    m_len   = (cfg_length == 0) ? 1 : longint'(cfg_length);
                    m_max   = int'(cfg_max_windows);
                    m_count = 0;
                    m_phase = (m_mode == 3) ? 3 : 1;
                end
                1: if ((int'(trig_in) & m_mask) != 0) begin
                    m_id    = lowest_bit(int'(trig_in) & m_mask);
                    m_start = t + 1 + m_delay;
                    m_end   = t + m_delay + m_len;
                    m_phase = 2;
                end
                2: if (t == m_end) begin
                    m_count = (m_count >= 255) ? 255 : m_count + 1;
                    m_phase = (m_mode == 1 || (m_max != 0 && m_count == m_max)) ? 4 : 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_all();
        int  e_state;
        bit  e_dump;
        e_state = m_phase;
        if (m_phase == 2) e_state = (cyc < m_start) ? 2 : 3;
        e_dump = (m_phase == 3) || (m_phase == 2 && cyc >= m_start);
        check("state",        32'(state),          32'(e_state));
        check("dump_en",      32'(dump_en),        32'(e_dump));
        check("dump_on",      32'(dump_on_pulse),  32'(e_dump && !m_dump_prev));
        check("dump_off",     32'(dump_off_pulse), 32'(!e_dump && m_dump_prev && !m_rst_edge));
        check("window_count", 32'(window_count),   32'(m_count));
        check("trig_hit_id",  32'(trig_hit_id),    32'(m_id));
        check("pulse_excl",   32'(dump_on_pulse & dump_off_pulse), 32'(0));
        m_dump_prev = e_dump;
        if (dump_en) n_dump_hi++;
        if (dump_off_pulse) n_off++;
    endtask

    // Inputs are set by the caller after the previous edge; the model takes
    // them at this edge and outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; force_off = 1'b0; cfg_mode = 2'd0;
        cfg_trig_mask = '0; cfg_delay = '0; cfg_length = '0;
        cfg_max_windows = '0; trig_in = '0;

        // Reset state, with arm and force_off asserted under reset.
        steps(2);
        arm = 1'b1; force_off = 1'b1; cfg_mode = 2'd1; step();
        arm = 1'b0; force_off = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_dump",  32'(dump_en), 32'd0);
        rst = 1'b0;
        steps(2);

        // One-shot, delay 3, length 5, channel 2.
        cfg_mode = 2'd1; cfg_delay = 3; cfg_length = 5; cfg_trig_mask = 4'b0100;
        pulse_arm();
        steps(3);
        trig_in = 4'b0100; step(); trig_in = '0;   // trigger cycle T
        steps(2);
        check("os_pre_dump", 32'(dump_en), 32'd0);  // T+3
        step();
        check("os_on", 32'(dump_on_pulse), 32'd1);  // T+4
        check("os_dump_first", 32'(dump_en), 32'd1);
        steps(4);
        check("os_dump_last", 32'(dump_en), 32'd1); // T+8
        step();
        check("os_off", 32'(dump_off_pulse), 32'd1); // T+9
        check("os_state", 32'(state), 32'd4);
        check("os_count", 32'(window_count), 32'd1);
        check("os_id", 32'(trig_hit_id), 32'd2);

        // Repeat, max 2, delay 0, length 2; second back-to-back trigger ignored.
        cfg_mode = 2'd2; cfg_max_windows = 2; cfg_delay = 0; cfg_length = 2;
        cfg_trig_mask = 4'b0001;
        pulse_arm();
        steps(4);
        trig_in = 4'b0001; step();
        check("rp_on", 32'(dump_on_pulse), 32'd1);
        step(); trig_in = '0;
        check("rp_dump2", 32'(dump_en), 32'd1);
        step();
        check("rp_rearm", 32'(state), 32'd1);
        check("rp_count1", 32'(window_count), 32'd1);
        steps(10);
        trig_in = 4'b0001; step(); trig_in = '0;
        steps(2);
        check("rp_done", 32'(state), 32'd4);
        check("rp_count2", 32'(window_count), 32'd2);

        // Masked-only triggers never fire.
        cfg_mode = 2'd1; cfg_trig_mask = 4'b0001;
        pulse_arm();
        trig_in = 4'b1110; steps(20); trig_in = '0;
        check("mk_state", 32'(state), 32'd1);
        check("mk_dump", 32'(dump_en), 32'd0);
        force_off = 1'b1; step(); force_off = 1'b0;

        // Continuous mode for 100 cycles.
        cfg_mode = 2'd3;
        n_dump_hi = 0; n_off = 0;
        pulse_arm();
        steps(99);
        force_off = 1'b1; step(); force_off = 1'b0;
        check("ct_dump_cycles", 32'(n_dump_hi), 32'd100);
        check("ct_off_count", 32'(n_off), 32'd1);
        check("ct_state", 32'(state), 32'd0);
        check("ct_count", 32'(window_count), 32'd0);

        // Length change and arms during CAPTURE, then same-cycle arm+force_off.
        cfg_mode = 2'd1; cfg_delay = 0; cfg_length = 6; cfg_trig_mask = 4'b1000;
        pulse_arm();
        trig_in = 4'b1000; step(); trig_in = '0;
        cfg_length = 1; step();
        pulse_arm();
        check("lc_still_cap", 32'(dump_en), 32'd1);
        arm = 1'b1; force_off = 1'b1; step(); arm = 1'b0; force_off = 1'b0;
        check("lc_off", 32'(dump_off_pulse), 32'd1);
        step();
        check("lc_idle", 32'(state), 32'd0);

        // Reset during DELAY, then a normal run.
        cfg_mode = 2'd1; cfg_delay = 5; cfg_length = 2; cfg_trig_mask = 4'b0010;
        pulse_arm();
        trig_in = 4'b0010; step(); trig_in = '0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        check("rd_state", 32'(state), 32'd0);
        check("rd_id", 32'(trig_hit_id), 32'd0);
        pulse_arm();
        trig_in = 4'b0010; step(); trig_in = '0;
        steps(7);
        check("rd_done", 32'(state), 32'd4);
        check("rd_count", 32'(window_count), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 299) == 0);
            force_off       = ($urandom_range(0, 119) == 0);
            arm             = ($urandom_range(0, 15) == 0);
            cfg_mode        = 2'($urandom_range(0, 3));
            cfg_trig_mask   = 4'($urandom);
            cfg_delay       = $urandom_range(0, 5);
            cfg_length      = $urandom_range(0, 6);
            cfg_max_windows = 8'($urandom_range(0, 3));
            trig_in         = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
